pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/hazard_pkg.sv | 28 ++
 rtl/hazard_md_timer.sv | 32 +++
 rtl/pipe_hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg : shared types and constants for the pipeline hazard controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package hazard_pkg;

    localparam int MD_CYCLES_DEFAULT = 32;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // $zero is hardwired, so a write to it never creates a dependency
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_md_timer.sv
// ---------------------------------------------------------------------------
// hazard_md_timer : 6-bit loadable down-counter timing a mult/div occupancy
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_md_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [5:0] i_load_val,
    input  logic       i_dec,
    output logic       o_zero
);

    logic [5:0] r_md_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_md_cnt <= 6'd0;
        end else if (i_load) begin
            r_md_cnt <= i_load_val;
        end else if (i_dec && (r_md_cnt != 6'd0)) begin
            r_md_cnt <= r_md_cnt - 6'd1;
        end
    end

    assign o_zero = (r_md_cnt == 6'd0);

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl : stall/flush/forward control for a 5-stage MIPS pipeline
// Optional HAZ_PERF_EN adds StallCnt/FlushCnt performance counters. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_CYCLES = MD_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] Rs_D,
    input  logic [4:0] Rt_D,
    input  logic [4:0] Rs_E,
    input  logic [4:0] Rt_E,
    input  logic [4:0] WriteReg_E,
    input  logic [4:0] WriteReg_M,
    input  logic [4:0] WriteReg_W,
    input  logic       RegWrite_E,
    input  logic       RegWrite_M,
    input  logic       RegWrite_W,
    input  logic       MemtoReg_E,
    input  logic       MemtoReg_M,
    input  logic       Branch_D,
    input  logic       Jr_D,
    input  logic       J_D,
    input  logic       PCSrc_D,
    input  logic       MdStart_E,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushD,
    output logic       EN_E,
    output logic       CLR_E,
    output logic       CLR_M,
    output logic [1:0] ForwardA_E,
    output logic [1:0] ForwardB_E,
    output logic       ForwardA_D,
    output logic       ForwardB_D,
    output logic       MdBusy
`ifdef HAZ_PERF_EN
    ,
    output logic [31:0] StallCnt,
    output logic [31:0] FlushCnt
`endif
);

    localparam logic [5:0] C_MD_LOAD = 6'(MD_CYCLES - 2);

    state_t r_state;
    state_t w_state_nxt;
    logic   w_lwstall;
    logic   w_brstall;
    logic   w_stall;
    logic   w_flush;
    logic   w_md_zero;
    logic   w_md_load;

    assign w_lwstall = MemtoReg_E & RegWrite_E &
                       (reg_match(WriteReg_E, Rs_D) | reg_match(WriteReg_E, Rt_D));
    assign w_brstall = (Branch_D | Jr_D) &
                       ((RegWrite_E & (reg_match(WriteReg_E, Rs_D) | reg_match(WriteReg_E, Rt_D))) |
                        (MemtoReg_M & (reg_match(WriteReg_M, Rs_D) | reg_match(WriteReg_M, Rt_D))));
    assign w_stall   = w_lwstall | w_brstall;
    assign w_flush   = PCSrc_D | J_D | Jr_D;
    assign w_md_load = (r_state == RUN) & MdStart_E;

    hazard_md_timer u_md_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_md_load),
        .i_load_val (C_MD_LOAD),
        .i_dec      (r_state == MD_BUSY),
        .o_zero     (w_md_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        StallF      = 1'b0;
        StallD      = 1'b0;
        FlushD      = 1'b0;
        EN_E        = 1'b1;
        CLR_E       = 1'b0;
        CLR_M       = 1'b0;
        MdBusy      = 1'b0;
        if (rst_n) begin
            case (r_state)
                MD_BUSY: begin
                    // Hold the multi-cycle op in E and bubble everything behind it
                    StallF = 1'b1;
                    StallD = 1'b1;
                    EN_E   = 1'b0;
                    CLR_M  = 1'b1;
                    MdBusy = 1'b1;
                    if (w_md_zero) begin
                        w_state_nxt = MD_DONE;
                    end
                end
                default: begin
                    if (w_stall) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        EN_E   = 1'b0;
                        CLR_E  = 1'b1;
                    end else if (w_flush) begin
                        FlushD = 1'b1;
                    end
                    w_state_nxt = (r_state == RUN && MdStart_E) ? MD_BUSY : RUN;
                end
            endcase
        end
    end

    always_comb begin
        ForwardA_E = FWD_RF;
        ForwardB_E = FWD_RF;
        if (RegWrite_M && reg_match(WriteReg_M, Rs_E)) begin
            ForwardA_E = FWD_M;
        end else if (RegWrite_W && reg_match(WriteReg_W, Rs_E)) begin
            ForwardA_E = FWD_W;
        end
        if (RegWrite_M && reg_match(WriteReg_M, Rt_E)) begin
            ForwardB_E = FWD_M;
        end else if (RegWrite_W && reg_match(WriteReg_W, Rt_E)) begin
            ForwardB_E = FWD_W;
        end
    end

    assign ForwardA_D = RegWrite_M & reg_match(WriteReg_M, Rs_D);
    assign ForwardB_D = RegWrite_M & reg_match(WriteReg_M, Rt_D);

`ifdef HAZ_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            r_stall_cnt <= r_stall_cnt + {31'd0, StallD};
            r_flush_cnt <= r_flush_cnt + {31'd0, FlushD};
        end
    end

    assign StallCnt = r_stall_cnt;
    assign FlushCnt = r_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl : directed vector table plus multi-cycle sequences
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pipe_hazard_ctrl;

    // control field order: StallF StallD FlushD EN_E CLR_E CLR_M MdBusy
    localparam logic [6:0] C_RUN   = 7'b0001000;
    localparam logic [6:0] C_STALL = 7'b1100100;
    localparam logic [6:0] C_FLUSH = 7'b0011000;
    localparam logic [6:0] C_BUSY  = 7'b1100011;

    typedef struct packed {
        logic [4:0]  rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
        logic        rw_e, rw_m, rw_w, m2r_e, m2r_m, br, jr, j, pcsrc;
        logic [12:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W;
    logic       RegWrite_E, RegWrite_M, RegWrite_W, MemtoReg_E, MemtoReg_M;
    logic       Branch_D, Jr_D, J_D, PCSrc_D, MdStart_E;
    logic       StallF, StallD, FlushD, EN_E, CLR_E, CLR_M, MdBusy;
    logic [1:0] ForwardA_E, ForwardB_E;
    logic       ForwardA_D, ForwardB_D;
`ifdef HAZ_PERF_EN
    logic [31:0] StallCnt, FlushCnt;
`endif

    int n_checks = 0;
    int n_err    = 0;
    vec_t vecs [17];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MD_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs_D(Rs_D), .Rt_D(Rt_D), .Rs_E(Rs_E), .Rt_E(Rt_E),
        .WriteReg_E(WriteReg_E), .WriteReg_M(WriteReg_M), .WriteReg_W(WriteReg_W),
        .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .MemtoReg_E(MemtoReg_E), .MemtoReg_M(MemtoReg_M),
        .Branch_D(Branch_D), .Jr_D(Jr_D), .J_D(J_D), .PCSrc_D(PCSrc_D),
        .MdStart_E(MdStart_E),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .EN_E(EN_E),
        .CLR_E(CLR_E), .CLR_M(CLR_M),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .ForwardA_D(ForwardA_D), .ForwardB_D(ForwardB_D),
        .MdBusy(MdBusy)
`ifdef HAZ_PERF_EN
        , .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
    );

    wire [12:0] w_act = {StallF, StallD, FlushD, EN_E, CLR_E, CLR_M, MdBusy,
                         ForwardA_E, ForwardB_E, ForwardA_D, ForwardB_D};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        Rs_D = v.rs_d; Rt_D = v.rt_d; Rs_E = v.rs_e; Rt_E = v.rt_e;
        WriteReg_E = v.wr_e; WriteReg_M = v.wr_m; WriteReg_W = v.wr_w;
        RegWrite_E = v.rw_e; RegWrite_M = v.rw_m; RegWrite_W = v.rw_w;
        MemtoReg_E = v.m2r_e; MemtoReg_M = v.m2r_m;
        Branch_D = v.br; Jr_D = v.jr; J_D = v.j; PCSrc_D = v.pcsrc;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        //          rs_d  rt_d  rs_e  rt_e  wr_e  wr_m  wr_w  rwE rwM rwW m2E m2M br jr j pc  expected
        vecs[0]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, {C_RUN,   6'b000000}};
        vecs[1]  = '{5'd2, 5'd0, 5'd0, 5'd0, 5'd2, 5'd0, 5'd0, 1, 0, 0, 1, 0, 0, 0, 0, 0, {C_STALL, 6'b000000}};
        vecs[2]  = '{5'd0, 5'd8, 5'd0, 5'd0, 5'd8, 5'd0, 5'd0, 1, 0, 0, 1, 0, 0, 0, 0, 0, {C_STALL, 6'b000000}};
        vecs[3]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 1, 0, 0, 0, 0, 0, {C_RUN,   6'b000000}};
        vecs[4]  = '{5'd3, 5'd0, 5'd0, 5'd0, 5'd2, 5'd0, 5'd0, 1, 0, 0, 1, 0, 0, 0, 0, 0, {C_RUN,   6'b000000}};
        vecs[5]  = '{5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 1, 0, 0, 0, 0, 1, 0, 0, 0, {C_STALL, 6'b000000}};
        vecs[6]  = '{5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, 0, 0, 1, {C_FLUSH, 6'b000000}};
        vecs[7]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 0, 1, 1, 0, 0, 0, 0, 0, 0, {C_RUN,   6'b100000}};
        vecs[8]  = '{5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 0, 0, 1, 0, 0, 0, 0, 0, 0, {C_RUN,   6'b000100}};
        vecs[9]  = '{5'd0, 5'd4, 5'd4, 5'd4, 5'd0, 5'd4, 5'd0, 0, 1, 0, 0, 0, 0, 0, 0, 0, {C_RUN,   6'b101001}};
        vecs[10] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 0, 0, 0, 0, 0, {C_RUN,   6'b000000}};
        vecs[11] = '{5'd0, 5'd4, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 0, 0, 0, 0, 1, 1, 0, 0, 0, {C_STALL, 6'b000000}};
        vecs[12] = '{5'd2, 5'd0, 5'd0, 5'd0, 5'd2, 5'd0, 5'd0, 1, 0, 0, 1, 0, 0, 0, 0, 1, {C_STALL, 6'b000000}};
        vecs[13] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0, {C_FLUSH, 6'b000000}};
        vecs[14] = '{5'd6, 5'd0, 5'd0, 5'd0, 5'd6, 5'd0, 5'd0, 1, 0, 0, 0, 0, 0, 1, 0, 0, {C_STALL, 6'b000000}};
        vecs[15] = '{5'd9, 5'd0, 5'd0, 5'd0, 5'd0, 5'd9, 5'd0, 0, 1, 0, 0, 0, 0, 0, 0, 0, {C_RUN,   6'b000010}};
        vecs[16] = '{5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, {C_RUN,   6'b000000}};

        rst_n = 1'b0;
        MdStart_E = 1'b0;
        drive(vecs[0]);

        // Reset forces control outputs while forwarding stays live
        tick();
        drive(vecs[1]);
        #1 check("reset_ctrl_forced", w_act, {C_RUN, 6'b000000});
        drive(vecs[9]);
        #1 check("reset_fwd_live", w_act, {C_RUN, 6'b101001});
`ifdef HAZ_PERF_EN
        check("reset_stallcnt", StallCnt, 32'd0);
`endif
        tick();
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            #1 check($sformatf("vec%0d", i), w_act, vecs[i].exp);
        end

        // lw stall clears once the load moves on
        tick();
        drive(vecs[1]);
        #1 check("lw_stall", w_act, {C_STALL, 6'b000000});
        tick();
        drive(vecs[0]);
        #1 check("lw_release", w_act, {C_RUN, 6'b000000});

        // mult/div with MD_CYCLES=4: RUN start, 3 busy, MD_DONE, RUN
        MdStart_E = 1'b1;
        #1 check("md_start", w_act, {C_RUN, 6'b000000});
        tick();
        PCSrc_D = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 check($sformatf("md_busy%0d", k), w_act, {C_BUSY, 6'b000000});
            tick();
        end
        #1 check("md_done", w_act, {C_FLUSH, 6'b000000});
        tick();
        MdStart_E = 1'b0;
        #1 check("md_back_run", w_act, {C_FLUSH, 6'b000000});
        tick();
        PCSrc_D = 1'b0;
        #1 check("md_stay_run", w_act, {C_RUN, 6'b000000});

        // reset on the second busy cycle aborts the op
        MdStart_E = 1'b1;
        tick();
        MdStart_E = 1'b0;
        #1 check("abort_busy1", w_act, {C_BUSY, 6'b000000});
        tick();
        rst_n = 1'b0;
        #1 check("abort_in_reset", w_act, {C_RUN, 6'b000000});
        tick();
        rst_n = 1'b1;
        #1 check("abort_run", w_act, {C_RUN, 6'b000000});
`ifdef HAZ_PERF_EN
        check("abort_stallcnt", StallCnt, 32'd0);
        check("abort_flushcnt", FlushCnt, 32'd0);
`endif
        tick();
        #1 check("abort_stay_run", w_act, {C_RUN, 6'b000000});

        // a fresh op after abort must run the full busy length
        MdStart_E = 1'b1;
        tick();
        MdStart_E = 1'b0;
        begin
            int n_busy = 0;
            for (int k = 0; k < 10; k++) begin
                #1 if (MdBusy) n_busy++;
                tick();
            end
            check("md_reload_len", n_busy, 32'd3);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
